// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one word request per cycle
// to a synchronous-read instruction memory and buffers {instr, pc} pairs in a FIFO.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [WIDTH-1:0] out_pc
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [WIDTH-1:0] pc_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_d [DEPTH];

  logic [CNT_W:0]   credit;
  logic [WIDTH-1:0] redirect_aligned;
  logic             issue;
  logic             push;
  logic             pop;

  // Credit counts the outstanding request too, so a returning word always has a slot.
  always_comb begin
    credit           = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    redirect_aligned = redirect_pc & ~WIDTH'(3);
    issue            = !rst && !redirect && (credit < DEPTH_C);
    push             = inflight_q && !redirect;
    pop              = (count_q != '0) && out_ready && !redirect;
  end

  always_comb begin
    fpc_d         = fpc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect) begin
      // Redirect wins over every other event: drop buffered and in-flight work.
      fpc_d    = redirect_aligned;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        fpc_d         = fpc_q + PC_STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = fpc_q;
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      fpc_q         <= fpc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= instr_mem_d[i];
        pc_mem_q[i]    <= pc_mem_d[i];
      end
    end
  end

  // Head outputs come straight from registered state; no path from out_ready.
  always_comb begin
    imem_req  = issue;
    imem_addr = fpc_q;
    out_valid = (count_q != '0);
    out_instr = instr_mem_q[rd_ptr_q];
    out_pc    = pc_mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory responder, reference queue of expected PCs,
// and explicit checks for reset, back-pressure, redirect and address wrap cases.
module tb_fetch_queue;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MASK  = 32'hA5A5_0000;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [31:0]      imem_rdata = JUNK;
  logic             redirect = 1'b0;
  logic [WIDTH-1:0] redirect_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [WIDTH-1:0] out_pc;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_fpc = '0;
  logic [WIDTH-1:0] pend_pc = '0;
  logic             pend = 1'b0;
  logic             m_req = 1'b0;
  logic             s_req = 1'b0;
  logic [WIDTH-1:0] s_addr = '0;

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample: compare DUT against the reference queue and fetch PC.
  task automatic look();
    #3;
    m_req = !redirect && ((exp_q.size() + (pend ? 1 : 0)) < DEPTH);
    chk("imem_req", {63'd0, imem_req}, {63'd0, m_req});
    chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_fpc});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("out_pc", {32'd0, out_pc}, {32'd0, exp_q[0]});
      chk("out_instr", {32'd0, out_instr}, {32'd0, exp_q[0] ^ MASK});
    end
    chk("count_bound", {63'd0, dut.count_q <= DEPTH}, 64'd1);
    s_req  = imem_req;
    s_addr = imem_addr;
  endtask

  // Advance the reference model across the clock edge, then answer the memory request.
  task automatic step_clk();
    if (redirect) begin
      exp_q.delete();
      pend  = 1'b0;
      m_fpc = redirect_pc & ~32'h3;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (pend) exp_q.push_back(pend_pc);
      pend = m_req;
      if (m_req) begin
        pend_pc = m_fpc;
        m_fpc   = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    imem_rdata = s_req ? (s_addr ^ MASK) : JUNK;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      look();
      step_clk();
    end
  endtask

  task automatic reset_async(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_instr"}, {32'd0, out_instr}, 64'd0);
    chk({tag, "_pc"}, {32'd0, out_pc}, 64'd0);
    exp_q.delete();
    pend     = 1'b0;
    m_fpc    = '0;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    imem_rdata = JUNK;
    @(posedge clk);
    #1;
    imem_rdata = JUNK;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nreq;
    #2;
    reset_async("rst0");

    // Streaming with out_ready held high.
    out_ready = 1'b1;
    look();
    chk("s1_c0_req", {63'd0, imem_req}, 64'd1);
    chk("s1_c0_addr", {32'd0, imem_addr}, 64'h0);
    step_clk();
    look();
    chk("s1_c1_valid", {63'd0, out_valid}, 64'd0);
    chk("s1_c1_addr", {32'd0, imem_addr}, 64'h4);
    step_clk();
    look();
    chk("s1_c2_valid", {63'd0, out_valid}, 64'd1);
    chk("s1_c2_pc", {32'd0, out_pc}, 64'h0);
    chk("s1_c2_instr", {32'd0, out_instr}, 64'hA5A5_0000);
    step_clk();
    for (int i = 0; i < 10; i++) begin
      look();
      chk("s1_stream_valid", {63'd0, out_valid}, 64'd1);
      chk("s1_stream_pc", {32'd0, out_pc}, {32'd0, 32'(4 * (i + 1))});
      step_clk();
    end

    // Back-pressure from reset: four requests then stall.
    reset_async("rst1");
    out_ready = 1'b0;
    nreq = 0;
    repeat (8) begin
      look();
      if (imem_req) nreq++;
      step_clk();
    end
    chk("s2_req_count", 64'(nreq), 64'd4);
    look();
    chk("s2_sat_valid", {63'd0, out_valid}, 64'd1);
    chk("s2_sat_pc", {32'd0, out_pc}, 64'h0);
    chk("s2_sat_count", {61'd0, dut.count_q}, 64'd4);
    step_clk();
    out_ready = 1'b1;
    look();
    chk("s2_pop_cycle_req", {63'd0, imem_req}, 64'd0);
    step_clk();
    look();
    chk("s2_resume_req", {63'd0, imem_req}, 64'd1);
    chk("s2_resume_addr", {32'd0, imem_addr}, 64'h10);
    step_clk();
    for (int i = 0; i < 24; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      run(1);
    end

    // Redirect with three buffered and one in flight, held for two cycles.
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    run(1);
    redirect = 1'b0;
    run(4);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    look();
    chk("s3_pre_count", {61'd0, dut.count_q}, 64'd3);
    chk("s3_r0_req", {63'd0, imem_req}, 64'd0);
    step_clk();
    redirect_pc = 32'h100;
    look();
    chk("s3_r1_req", {63'd0, imem_req}, 64'd0);
    step_clk();
    redirect  = 1'b0;
    out_ready = 1'b1;
    look();
    chk("s3_p1_valid", {63'd0, out_valid}, 64'd0);
    chk("s3_p1_req", {63'd0, imem_req}, 64'd1);
    chk("s3_p1_addr", {32'd0, imem_addr}, 64'h100);
    step_clk();
    look();
    chk("s3_p2_valid", {63'd0, out_valid}, 64'd0);
    step_clk();
    look();
    chk("s3_p3_valid", {63'd0, out_valid}, 64'd1);
    chk("s3_p3_pc", {32'd0, out_pc}, 64'h100);
    step_clk();
    run(4);

    // Redirect coinciding with a pop and a returning response; low bits dropped.
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    look();
    chk("s4_r_valid", {63'd0, out_valid}, 64'd1);
    chk("s4_r_req", {63'd0, imem_req}, 64'd0);
    step_clk();
    redirect = 1'b0;
    look();
    chk("s4_p1_addr", {32'd0, imem_addr}, 64'h200);
    chk("s4_p1_valid", {63'd0, out_valid}, 64'd0);
    step_clk();
    run(1);
    look();
    chk("s4_p3_pc", {32'd0, out_pc}, 64'h200);
    step_clk();
    run(3);

    // Asynchronous reset with two buffered and one in flight.
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    run(1);
    redirect = 1'b0;
    run(3);
    look();
    chk("s5_pre_count", {61'd0, dut.count_q}, 64'd2);
    reset_async("s5_rst");
    out_ready = 1'b1;
    look();
    chk("s5_c0_addr", {32'd0, imem_addr}, 64'h0);
    step_clk();
    look();
    chk("s5_c1_valid", {63'd0, out_valid}, 64'd0);
    step_clk();
    look();
    chk("s5_c2_pc", {32'd0, out_pc}, 64'h0);
    step_clk();
    run(4);

    // Fetch PC wraps past the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    run(1);
    redirect = 1'b0;
    run(2);
    look();
    chk("s6_pc0", {32'd0, out_pc}, 64'hFFFF_FFF8);
    step_clk();
    look();
    chk("s6_pc1", {32'd0, out_pc}, 64'hFFFF_FFFC);
    step_clk();
    look();
    chk("s6_pc2", {32'd0, out_pc}, 64'h0);
    step_clk();
    look();
    chk("s6_pc3", {32'd0, out_pc}, 64'h4);
    step_clk();
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that owns the fetch PC, issues word requests to a synchronous-read instruction memory, and buffers returned instructions with their PCs in a small FIFO. The FIFO head drives the IF/ID pipeline register. Decode consumes an entry on `out_valid && out_ready`, where `out_ready` is the pipeline-advance signal. A taken branch or jump from later stages redirects fetch and flushes everything buffered or in flight.

## Interface
Parameters:
- WIDTH, 32, PC/address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request issued this cycle.
- imem_addr  out  WIDTH  fetch address; always equals the fetch PC `fpc`.
- imem_rdata  in  32  instruction word; valid exactly one cycle after the cycle in which `imem_req` was high.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  WIDTH  new fetch address; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  consumer accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  WIDTH  PC of the head instruction.

## Operation
State:
- `fpc`: fetch PC.
- `count`: 0..DEPTH.
- Read and write pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
- `inflight`: 1 bit.
- `inflight_pc`: PC of the outstanding request.
- Storage array of {instr, pc}.

Issue:
- `imem_req = !redirect && (count + inflight < DEPTH)`.
- The issue check uses the current-cycle `count` only; a same-cycle pop does not open a slot.
- On issue: `fpc <= fpc + 4` (wraps modulo 2^WIDTH), `inflight <= 1`, `inflight_pc <= fpc`.
- With no issue: `inflight <= 0`.

Return:
- When `inflight == 1` and no redirect is active this cycle, write {imem_rdata, inflight_pc} at the write pointer, then advance the write pointer.

Pop:
- `out_valid = (count != 0)`.
- When `out_valid && out_ready && !redirect`, advance the read pointer.
- `out_instr` and `out_pc` show the storage at the read pointer. They are don't-care only when `out_valid == 0`; after reset they read 0.

Count:
- Push only: +1. Pop only: −1. Push and pop together: unchanged.
- Overflow is impossible by construction (credit includes `inflight`). The bench asserts `count` never exceeds DEPTH.

Redirect (dominates all other events in its cycle):
- `count <= 0`; read and write pointers reset to 0.
- `inflight <= 0`, so any response arriving in this cycle is discarded.
- `fpc <= {redirect_pc[WIDTH-1:2], 2'b00}`.
- `imem_req` is 0 in the redirect cycle. The first request to the new PC issues in the next cycle.
- Back-to-back redirects: the last one wins, and no request issues until the cycle after `redirect` drops.

Reset (asynchronous, at any time, including mid-stream):
- `fpc = RESET_PC`; `count`, pointers and `inflight` are 0; storage is 0.
- `imem_req`, `out_valid`, `out_instr` and `out_pc` are all 0 while `rst` is high.
- A response arriving in the first cycle after reset release is ignored, because `inflight` is 0.

## Timing
- Request in cycle N; data captured at the end of cycle N+1; `out_valid` high in cycle N+2. Request-to-output latency is 2 cycles, with no bypass.
- First request is cycle 0 after reset release, so the first `out_valid` is cycle 2.
- Steady state with `out_ready` held high: one instruction per cycle, sequential PCs, no bubbles.
- With `out_ready` low: requests stop once `count + inflight == DEPTH`. After `out_ready` returns high, requests resume one cycle after the first pop.
- Redirect in cycle R: first new request in R+1; first new `out_valid` in R+3.
- `out_valid`, `out_instr` and `out_pc` are registered-state outputs with no combinational path from `out_ready`.
- `imem_req` and `imem_addr` depend combinationally only on `redirect` and internal state.

## Test plan
- Reset then run with `out_ready = 1` and `imem_rdata = addr ^ 32'hA5A5_0000`: `imem_addr` sequence 0, 4, 8, …; `out_valid` first high at cycle 2; `out_pc`/`out_instr` pairs match with no gaps.
- Hold `out_ready = 0` from reset: exactly 4 requests (addr 0x0–0xC), `count` saturates at 4 with `out_valid = 1` and `out_pc = 0`. Raise `out_ready`: the next request (0x10) issues one cycle after the first pop.
- Redirect to 0x100 while one request is in flight and 3 entries are buffered: the next cycle has `out_valid = 0`, `imem_req = 1` and `imem_addr = 0x100`; the stale response never appears; `out_pc = 0x100` at R+3.
- Redirect with `redirect_pc = 0x203` in the same cycle as a valid pop and a returning response: the pop and push are both ignored; the next fetch address is 0x200.
- Assert `rst` mid-stream (`count = 2`, `inflight = 1`): outputs go to 0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC and no pre-reset instruction is delivered.
- Redirect to 32'hFFFF_FFF8: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
